// File: rtl/seq_shift_add_multiplier.sv
// seq_shift_add_multiplier: MxQ multiplier retiring one multiplier bit per cycle through a single adder/subtractor
module seq_shift_add_multiplier #(
  parameter int M_WIDTH = 3,
  parameter int Q_WIDTH = 2
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       start,
  input  logic                       signedMode,
  input  logic [M_WIDTH-1:0]         m,
  input  logic [Q_WIDTH-1:0]         q,
  output logic                       busy,
  output logic                       done,
  output logic [M_WIDTH+Q_WIDTH-1:0] product
);
  localparam int P = M_WIDTH + Q_WIDTH;
  localparam int CW = $clog2(Q_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(Q_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             r_state;
  logic [M_WIDTH-1:0] r_m;
  logic [Q_WIDTH-1:0] r_q;
  logic               r_signed;
  logic [CW-1:0]      r_cnt;
  logic [P-1:0]       r_acc;
  logic [P-1:0]       r_product;
  logic               r_busy;
  logic               r_done;
  logic [P-1:0]       w_ext;
  logic [P-1:0]       w_addend;
  logic [P-1:0]       w_acc_next;
  logic               w_last;
  always_comb begin
    w_last     = r_cnt == LAST;
    w_ext      = {{Q_WIDTH{r_signed & r_m[M_WIDTH-1]}}, r_m};
    w_addend   = w_ext << r_cnt;
    // the top multiplier bit carries negative weight in two's complement
    w_acc_next = !r_q[r_cnt] ? r_acc : (w_last && r_signed) ? r_acc - w_addend : r_acc + w_addend;
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_m       <= '0;
      r_q       <= '0;
      r_signed  <= 1'b0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_acc_next;
            r_done    <= 1'b1;
            r_busy    <= 1'b0;
            r_state   <= DONE;
          end
        end
        default: begin
          r_done <= 1'b0;
          if (start) begin
            r_m      <= m;
            r_q      <= q;
            r_signed <= signedMode;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end
  assign busy    = r_busy;
  assign done    = r_done;
  assign product = r_product;
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// tb_seq_shift_add_multiplier: directed and random checks of the default 3x2 and an 8x6 instance
module tb_seq_shift_add_multiplier;
  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        s_start = 1'b0, s_sm = 1'b0, s_busy, s_done;
  logic [2:0]  s_m = '0;
  logic [1:0]  s_q = '0;
  logic [4:0]  s_prod;
  logic        w_start = 1'b0, w_sm = 1'b0, w_busy, w_done;
  logic [7:0]  w_m = '0;
  logic [5:0]  w_q = '0;
  logic [13:0] w_prod;
  longint      exp_q[$];
  int          n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  seq_shift_add_multiplier u_small (
    .clk(clk), .rstN(rstN), .start(s_start), .signedMode(s_sm), .m(s_m), .q(s_q),
    .busy(s_busy), .done(s_done), .product(s_prod)
  );
  seq_shift_add_multiplier #(.M_WIDTH(8), .Q_WIDTH(6)) u_wide (
    .clk(clk), .rstN(rstN), .start(w_start), .signedMode(w_sm), .m(w_m), .q(w_q),
    .busy(w_busy), .done(w_done), .product(w_prod)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint model(input longint a, input longint b, input int mw, input int qw, input bit sg);
    longint sa, sb;
    sa = (sg && a[mw-1]) ? a - (64'sd1 << mw) : a;
    sb = (sg && b[qw-1]) ? b - (64'sd1 << qw) : b;
    return (sa * sb) & ((64'sd1 << (mw + qw)) - 1);
  endfunction

  task automatic s_go(input int a, input int b, input bit sg);
    s_m = 3'(a); s_q = 2'(b); s_sm = sg; s_start = 1'b1;
    exp_q.push_back(model(a, b, 3, 2, sg));
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("s_busy_run", s_busy, 1);
    chk("s_done_run", s_done, 0);
  endtask

  task automatic s_wait(input string tag, input int lat);
    int c = 0;
    do begin @(posedge clk); #1; c++; end while (!s_done && c < 20);
    chk({tag, "_lat"}, c, lat);
    chk({tag, "_prod"}, s_prod, exp_q.pop_front());
    chk({tag, "_busy"}, s_busy, 0);
  endtask

  task automatic w_go(input int a, input int b, input bit sg);
    w_m = 8'(a); w_q = 6'(b); w_sm = sg; w_start = 1'b1;
    exp_q.push_back(model(a, b, 8, 6, sg));
    @(posedge clk); #1;
    w_start = 1'b0;
  endtask

  task automatic w_wait(input string tag);
    int c = 0;
    do begin @(posedge clk); #1; c++; end while (!w_done && c < 40);
    chk({tag, "_lat"}, c, 6);
    chk({tag, "_prod"}, w_prod, exp_q.pop_front());
  endtask

  initial begin
    int dn;
    #12;
    chk("rst_busy", s_busy, 0);
    chk("rst_done", s_done, 0);
    chk("rst_prod", s_prod, 0);
    chk("rst_wprod", w_prod, 0);
    @(negedge clk) rstN = 1'b1;
    @(posedge clk); #1;
    // unsigned 7x3 with hold check
    s_go(7, 3, 0);
    s_wait("u7x3", 2);
    @(posedge clk); #1;
    chk("u7x3_done_low", s_done, 0);
    chk("u7x3_hold", s_prod, 21);
    // same bit patterns, both modes
    s_go(5, 3, 1);
    s_wait("s101x11", 2);
    s_go(5, 3, 0);
    s_wait("u101x11", 2);
    s_go(4, 2, 1);
    s_wait("sm4xm2", 2);
    // start during RUN is ignored
    s_go(7, 3, 0);
    s_m = 3'd1; s_q = 2'd1; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_wait("ign", 1);
    dn = 0;
    for (int i = 0; i < 5; i++) begin @(posedge clk); #1; dn += int'(s_done | s_busy); end
    chk("ign_no_extra", dn, 0);
    // back-to-back through DONE
    s_go(7, 3, 0);
    s_wait("b2b1", 2);
    s_m = 3'd2; s_q = 2'd2; s_sm = 1'b0; s_start = 1'b1;
    exp_q.push_back(model(2, 2, 3, 2, 0));
    @(posedge clk); #1;
    s_start = 1'b0;
    chk("b2b_busy", s_busy, 1);
    s_wait("b2b2", 2);
    // asynchronous reset mid-operation
    s_go(7, 3, 0);
    #2 rstN = 1'b0;
    #1;
    chk("arst_busy", s_busy, 0);
    chk("arst_done", s_done, 0);
    chk("arst_prod", s_prod, 0);
    exp_q.delete();
    @(negedge clk) rstN = 1'b1;
    dn = 0;
    for (int i = 0; i < 6; i++) begin @(posedge clk); #1; dn += int'(s_done); end
    chk("arst_no_done", dn, 0);
    // 8x6 corners and random sweep
    w_go(255, 63, 0);
    w_wait("w_u_max");
    chk("w_u_max_val", w_prod, 16065);
    w_go(128, 32, 1);
    w_wait("w_s_min");
    chk("w_s_min_val", w_prod, 4096);
    for (int i = 0; i < 16; i++) begin
      w_go(int'($urandom_range(0, 255)), int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      w_wait("w_rand");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
